// File: rtl/axi_wrr_arbiter.sv
// Weighted round-robin arbiter for AXI Ax-channel streams with a one-deep registered output stage.
// Optional macro WRR_WEIGHT_CFG_EN adds runtime weight load ports (weight_i, weight_load_i).
module axi_wrr_arbiter #(
  parameter int unsigned INPUT_NUM      = 3,
  parameter int unsigned DATA_WIDTH     = 33,
  parameter int unsigned WEIGHT_WIDTH   = 4,
  parameter int unsigned DEFAULT_WEIGHT = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [DATA_WIDTH-1:0]         data_i [INPUT_NUM],
  input  logic [INPUT_NUM-1:0]          valid_i,
  output logic [INPUT_NUM-1:0]          ready_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(INPUT_NUM)-1:0]  grant_o
`ifdef WRR_WEIGHT_CFG_EN
  ,
  input  logic [INPUT_NUM*WEIGHT_WIDTH-1:0] weight_i,
  input  logic                              weight_load_i
`endif
);

  localparam int unsigned IDX_W = $clog2(INPUT_NUM);

  typedef logic [WEIGHT_WIDTH-1:0] cnt_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef enum logic {EMPTY, FULL} state_t;

  localparam cnt_t DEF_W = (DEFAULT_WEIGHT == 0) ? cnt_t'(1) : cnt_t'(DEFAULT_WEIGHT);

  function automatic cnt_t fix_weight(cnt_t w);
    return (w == '0) ? cnt_t'(1) : w;
  endfunction

  state_t         state, state_nxt;
  idx_t           ptr, ptr_nxt;
  cnt_t           credit [INPUT_NUM];
  cnt_t           weight [INPUT_NUM];

  logic [INPUT_NUM-1:0] elig, mask;
  logic                 reload, win_found, accept, take;
  idx_t                 win_idx;
  logic [IDX_W:0]       scan;
  cnt_t                 base, dec;

`ifdef WRR_WEIGHT_CFG_EN
  cnt_t weight_q [INPUT_NUM];
  always_comb begin
    for (int unsigned k = 0; k < INPUT_NUM; k++) weight[k] = weight_q[k];
  end
`else
  always_comb begin
    for (int unsigned k = 0; k < INPUT_NUM; k++) weight[k] = DEF_W;
  end
`endif

  // An exhausted-but-requesting set reloads in the same cycle, so the winner
  // is then chosen among all valid inputs rather than only credited ones.
  always_comb begin
    elig      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int unsigned k = 0; k < INPUT_NUM; k++)
      elig[k] = valid_i[k] && (credit[k] != '0);
    reload = (elig == '0) && (valid_i != '0);
    mask   = reload ? valid_i : elig;
    for (int unsigned i = 0; i < INPUT_NUM; i++) begin
      scan = {1'b0, ptr} + (IDX_W+1)'(i);
      if (scan >= (IDX_W+1)'(INPUT_NUM)) scan = scan - (IDX_W+1)'(INPUT_NUM);
      if (!win_found && mask[scan[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    base    = reload ? weight[win_idx] : credit[win_idx];
    dec     = (base == '0) ? '0 : base - 1'b1;
    if (dec == '0)
      ptr_nxt = (win_idx == IDX_W'(INPUT_NUM-1)) ? '0 : win_idx + 1'b1;
    else
      ptr_nxt = win_idx;
  end

  always_comb begin
    state_nxt = state;
    accept    = (state == EMPTY) || ready_i;
    take      = accept && win_found;
    ready_o   = '0;
    if (take && ARESETn) ready_o[win_idx] = 1'b1;
    case (state)
      EMPTY:   if (take) state_nxt = FULL;
      FULL:    if (ready_i) state_nxt = take ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
    valid_o = (state == FULL);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      data_o  <= '0;
      grant_o <= '0;
    end else if (take) begin
      data_o  <= data_i[win_idx];
      grant_o <= win_idx;
    end
  end

  // A weight load takes priority over the arbitration credit update.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ptr <= '0;
      for (int unsigned k = 0; k < INPUT_NUM; k++) begin
        credit[k] <= DEF_W;
`ifdef WRR_WEIGHT_CFG_EN
        weight_q[k] <= DEF_W;
`endif
      end
    end else begin
`ifdef WRR_WEIGHT_CFG_EN
      if (weight_load_i) begin
        ptr <= '0;
        for (int unsigned k = 0; k < INPUT_NUM; k++) begin
          weight_q[k] <= fix_weight(weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
          credit[k]   <= fix_weight(weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        end
      end else
`endif
      if (take) begin
        if (reload)
          for (int unsigned k = 0; k < INPUT_NUM; k++) credit[k] <= weight[k];
        credit[win_idx] <= dec;
        ptr             <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_axi_wrr_arbiter.sv
// Directed bench for axi_wrr_arbiter: a weight-1 instance and a weight-2 instance share stimulus.
module tb_axi_wrr_arbiter;
  localparam int N  = 3;
  localparam int DW = 33;
  localparam int WW = 4;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [DW-1:0] data_i [N];
  logic [N-1:0]  valid_i;
  logic          ready_i;
  logic [N-1:0]  ready_o, ready_o2;
  logic [DW-1:0] data_o, data_o2;
  logic          valid_o, valid_o2;
  logic [1:0]    grant_o, grant_o2;
`ifdef WRR_WEIGHT_CFG_EN
  logic [N*WW-1:0] weight_i;
  logic            weight_load_i;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  axi_wrr_arbiter #(.INPUT_NUM(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .DEFAULT_WEIGHT(1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .grant_o(grant_o)
`ifdef WRR_WEIGHT_CFG_EN
    , .weight_i(weight_i), .weight_load_i(weight_load_i)
`endif
  );

  axi_wrr_arbiter #(.INPUT_NUM(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .DEFAULT_WEIGHT(2)) dut2 (
    .ACLK(ACLK), .ARESETn(ARESETn), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o2),
    .data_o(data_o2), .valid_o(valid_o2), .ready_i(ready_i), .grant_o(grant_o2)
`ifdef WRR_WEIGHT_CFG_EN
    , .weight_i(weight_i), .weight_load_i(weight_load_i)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: checks the same-cycle ready, then the registered result after the edge.
  task automatic win(input string tag, input int unsigned w, input bit second);
    logic [63:0] exp_data;
    exp_data = 64'(data_i[w]);
    #1;
    check({tag, "_ready"}, second ? 64'(ready_o2) : 64'(ready_o), 64'(1) << w);
    @(posedge ACLK); #1;
    check({tag, "_grant"}, second ? 64'(grant_o2) : 64'(grant_o), 64'(w));
    check({tag, "_valid"}, second ? 64'(valid_o2) : 64'(valid_o), 64'(1));
    check({tag, "_data"},  second ? 64'(data_o2)  : 64'(data_o),  exp_data);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    valid_i = '0;
    ready_i = 1'b0;
    #2;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
  endtask

  initial begin
    int unsigned pat [6];
    valid_i = '1;
    ready_i = 1'b1;
    for (int k = 0; k < N; k++) data_i[k] = DW'(32'h100 + k);
`ifdef WRR_WEIGHT_CFG_EN
    weight_i      = '0;
    weight_load_i = 1'b0;
`endif
    #3;
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_data",  64'(data_o),  64'(0));
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_valid2", 64'(valid_o2), 64'(0));
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Equal weights, all requesting: plain rotation with same-cycle reload
    for (int g = 0; g < 6; g++) win($sformatf("rr%0d", g), g % 3, 1'b0);
    valid_i = '0;
    #1 check("rr_idle_ready", 64'(ready_o), 64'(0));
    @(posedge ACLK); #1;
    check("rr_drain_valid", 64'(valid_o), 64'(0));

    // Backpressure holds the registered output stage
    do_reset();
    valid_i    = 3'b010;
    data_i[1]  = DW'(33'h1ABCD);
    ready_i    = 1'b0;
    win("bp_first", 1, 1'b0);
    data_i[1]  = DW'(33'h02222);
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("bp%0d_ready", c), 64'(ready_o), 64'(0));
      @(posedge ACLK); #1;
      check($sformatf("bp%0d_data", c),  64'(data_o),  64'h1ABCD);
      check($sformatf("bp%0d_grant", c), 64'(grant_o), 64'(1));
      check($sformatf("bp%0d_valid", c), 64'(valid_o), 64'(1));
    end
    ready_i = 1'b1;
    valid_i = '0;
    #1 check("bp_drain_ready", 64'(ready_o), 64'(0));
    @(posedge ACLK); #1;
    check("bp_drain_valid", 64'(valid_o), 64'(0));

    // Single requester, weight 1: reload every cycle, no bubble
    do_reset();
    for (int k = 0; k < N; k++) data_i[k] = DW'(32'h300 + k);
    valid_i = 3'b100;
    ready_i = 1'b1;
    for (int c = 0; c < 4; c++) win($sformatf("solo%0d", c), 2, 1'b0);

    // Weight 2: input 0 keeps its leftover credit while absent
    do_reset();
    for (int k = 0; k < N; k++) data_i[k] = DW'(32'h500 + k);
    valid_i = 3'b111;
    ready_i = 1'b1;
    win("w2_a", 0, 1'b1);
    valid_i = 3'b110;
    win("w2_b", 1, 1'b1);
    valid_i = 3'b111;
    win("w2_c", 1, 1'b1);
    win("w2_d", 2, 1'b1);
    win("w2_e", 2, 1'b1);
    win("w2_f", 0, 1'b1);
    win("w2_g", 1, 1'b1);

    // Asynchronous reset while the output stage is full
    do_reset();
    for (int k = 0; k < N; k++) data_i[k] = DW'(32'h700 + k);
    valid_i = 3'b111;
    ready_i = 1'b1;
    win("ar_pre", 0, 1'b0);
    #2 ARESETn = 1'b0;
    #1;
    check("ar_valid", 64'(valid_o), 64'(0));
    check("ar_grant", 64'(grant_o), 64'(0));
    check("ar_ready", 64'(ready_o), 64'(0));
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    win("ar_post", 0, 1'b0);

`ifdef WRR_WEIGHT_CFG_EN
    // Loaded weights 3,1,2
    do_reset();
    weight_i      = {4'd2, 4'd1, 4'd3};
    weight_load_i = 1'b1;
    @(posedge ACLK); #1;
    weight_load_i = 1'b0;
    valid_i = 3'b111;
    ready_i = 1'b1;
    pat = '{0, 0, 0, 1, 2, 2};
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 6; j++) win($sformatf("cfg%0d_%0d", r, j), pat[j], 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
